player_motion: RTL
==================

# player_motion

Per-player motion and animation controller between the NES controller reader and the sprite renderer. Once per video frame it reads the player's active-low button vector and integrates horizontal run, jump and gravity. It also resolves collisions with the floor, the screen edges and an optional single platform. It outputs the sprite's top-left screen position, facing direction and sprite-sheet frame offsets, which the renderer uses for address generation.

## Interface

Parameters:
- X_INIT, 0 — reset x (screen pixels)
- Y_INIT, 0 — reset y
- FACING_INIT, 0 — reset facing_right
- SCREEN_W, 640 — screen width
- SPRITE_W, 46 — on-screen sprite width (2× scaled)
- SPRITE_H, 60 — on-screen sprite height
- GROUND_Y, 420 — floor y for the sprite top
- RUN_SPEED, 5 — px per frame
- JUMP_VEL, 12 — initial upward speed, px/frame
- GRAVITY, 1 — px/frame² added to vy
- MAX_FALL, 10 — vy saturation
- ANIM_DIV, 6 — frames per run-animation step
- PLT_X, 270; PLT_Y, 300; PLT_W, 100 — platform rectangle top edge

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-clk pulse per frame (from the VGA block)
- buttons  in  8  active-low: [0] right, [1] left, [2] down, [3] up, [4] start, [5] select, [6] B, [7] A
- pos_x  out  10  sprite left x
- pos_y  out  10  sprite top y
- facing_right  out  1
- anim_row  out  10  sheet row offset, 0 or 30
- anim_col  out  10  sheet col offset, 0/23/46
- on_ground  out  1  high in IDLE or RUN
- mstate  out  2  IDLE=0, RUN=1, JUMP=2, FALL=3

## Operation

- All state updates only on a clk edge where frame_tick=1. Otherwise every register holds.
- Reset values: pos_x=X_INIT, pos_y=Y_INIT, facing_right=FACING_INIT, vy=0, mstate=FALL, anim frame=0 (anim_row=0, anim_col=0), on_ground=0, a_prev=0.
- Horizontal movement, applied in every state:
  - Right only: x+=RUN_SPEED, clamped to SCREEN_W-SPRITE_W; facing_right=1.
  - Left only: x-=RUN_SPEED, clamped to 0 (x<RUN_SPEED gives 0); facing_right=0.
  - Both or neither: x and facing unchanged.
- Jump: A-edge = A pressed this tick and not pressed on the previous tick (a_prev). A held does not re-jump.
- Vertical arithmetic is 12-bit signed. vy is signed 8-bit.
- IDLE/RUN:
  - A-edge → vy=-JUMP_VEL, JUMP. The first displacement is applied on the next tick.
  - Else mstate = RUN if exactly one of left/right is pressed, otherwise IDLE.
- JUMP/FALL:
  - ny=y+vy; vy=min(vy+GRAVITY, MAX_FALL).
  - ny<0 → y=0, vy=0, FALL (ceiling).
  - ny≥GROUND_Y → y=GROUND_Y, vy=0, land.
  - Else y=ny; state becomes FALL once the new vy≥0.
- Land: mstate = RUN if horizontal input is active, otherwise IDLE; on_ground=1.
- Animation frames: frame index f maps as 0:(0,0) 1:(0,23) 2:(0,46) 3:(30,0) 4:(30,23) 5:(30,46), given as (anim_row, anim_col).
  - IDLE: f=0.
  - RUN: an internal tick counter advances f by one every ANIM_DIV ticks, wrapping 5→0. Entering RUN resets f=0 and the counter to 0.
  - JUMP: f=3.
  - FALL: f=4.

## Timing

- Latency: outputs reflect a tick's inputs on the clk edge at which frame_tick is sampled high. They are stable for the whole following frame.
- buttons must be stable for the cycle where frame_tick=1. No other sampling occurs.
- rst wins over frame_tick in the same cycle.
- Back-to-back frame_tick pulses, one per clk, are legal. Each pulse is a full update.
- Horizontal and vertical updates in the same tick are independent. The platform overlap test uses the new x.

## Configuration

- PLAYER_PLATFORM_EN defined: one-way platform enabled.
  - Landing: in FALL with y+SPRITE_H≤PLT_Y and ny+SPRITE_H≥PLT_Y and horizontal overlap (x+SPRITE_W>PLT_X and x<PLT_X+PLT_W) → y=PLT_Y-SPRITE_H, vy=0, land.
  - Walking off: on the platform with no horizontal overlap after the move → FALL, vy=0.
  - Down pressed while on the platform → y+=1, FALL (drop-through; the crossing test then fails).
  - The platform is never solid from below.
- Undefined: only the floor and ceiling exist. The down button is ignored.

## Test plan

- Reset with X_INIT=100, Y_INIT=0, then ticks with no buttons → FALL, vy 0,1,2…10 saturating. y lands at exactly 420 → IDLE, on_ground=1, anim (0,0).
- On ground at x=600, right held 3 ticks → x=594 after first tick (clamp 640-46). Then left held 1 tick → x=589, facing_right=0. Both held → x unchanged, IDLE.
- On ground, A held 40 ticks → exactly one jump: vy=-12, JUMP with anim (30,0). Apex when vy≥0 → FALL with (30,23). Returns to y=420, with no second jump until A is released and pressed again.
- RUN held 36 ticks → f sequence 0 (6 ticks),1,2,3,4,5, then wraps to 0 at tick 36. Releasing gives IDLE f=0.
- PLAYER_PLATFORM_EN, x=300, falling from y=200 → lands y=240. Down → y=241, FALL, lands 420. Walking right past x=370 off the platform → FALL.
- rst asserted mid-jump in the same cycle as frame_tick → all outputs at reset values next cycle.

Source files
------------

// File: rtl/player_motion_if.sv
// Per-player motion bus: frame strobe and buttons in, sprite pose out.
// No latency of its own; plain wires between the frame source and the motion block.
// No backpressure: the frame strobe is a one-cycle pulse that is always accepted.
interface player_motion_if;
  logic       frame_tick;
  logic [7:0] buttons;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       facing_right;
  logic [9:0] anim_row;
  logic [9:0] anim_col;
  logic       on_ground;
  logic [1:0] mstate;

  // Frame source / controller side
  modport master (
    output frame_tick, buttons,
    input  pos_x, pos_y, facing_right, anim_row, anim_col, on_ground, mstate
  );

  // Motion controller side
  modport slave (
    input  frame_tick, buttons,
    output pos_x, pos_y, facing_right, anim_row, anim_col, on_ground, mstate
  );
endinterface

// File: rtl/player_motion.sv
// Per-frame player motion: run, jump, gravity, floor/ceiling/screen-edge collisions, sprite frame select.
// Latency: outputs update on the clk edge where frame_tick is sampled high, then hold for the frame.
// No backpressure: every frame_tick is a full update; PLAYER_PLATFORM_EN adds a one-way platform.
module player_motion #(
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter bit FACING_INIT = 1'b0,
  parameter int SCREEN_W    = 640,
  parameter int SPRITE_W    = 46,
  parameter int SPRITE_H    = 60,
  parameter int GROUND_Y    = 420,
  parameter int RUN_SPEED   = 5,
  parameter int JUMP_VEL    = 12,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 10,
  parameter int ANIM_DIV    = 6,
  parameter int PLT_X       = 270,
  parameter int PLT_Y       = 300,
  parameter int PLT_W       = 100
) (
  input  logic            clk,
  input  logic            rst,
  player_motion_if.slave  pm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_JUMP = 2'd2,
    S_FALL = 2'd3
  } mstate_t;

  localparam logic [10:0]        X_MAX    = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0]        RUN_V    = 11'(RUN_SPEED);
  localparam logic [10:0]        SPR_W    = 11'(SPRITE_W);
  localparam logic [10:0]        PLT_L    = 11'(PLT_X);
  localparam logic [10:0]        PLT_R    = 11'(PLT_X + PLT_W);
  localparam logic signed [11:0] GND_Y    = 12'(GROUND_Y);
  localparam logic signed [11:0] PLT_TOP  = 12'(PLT_Y - SPRITE_H);
  localparam logic signed [7:0]  VY_JUMP  = 8'(-JUMP_VEL);
  localparam logic signed [8:0]  VY_MAX   = 9'(MAX_FALL);
  localparam logic signed [8:0]  VY_GRAV  = 9'(GRAVITY);
  localparam logic [7:0]         CNT_LAST = 8'(ANIM_DIV - 1);

  logic [9:0]        x_q, y_q;
  logic              fr_q;
  logic signed [7:0] vy_q;
  mstate_t           st_q;
  logic [2:0]        f_q;
  logic [7:0]        cnt_q;
  logic              a_prev_q;
  logic              og_q;
  logic              on_plt_q;

  logic btn_r, btn_l, btn_d, btn_a, one_dir, a_edge;
  assign btn_r   = ~pm.buttons[0];
  assign btn_l   = ~pm.buttons[1];
  assign btn_d   = ~pm.buttons[2];
  assign btn_a   = ~pm.buttons[7];
  assign one_dir = btn_r ^ btn_l;
  assign a_edge  = btn_a & ~a_prev_q;

  logic [10:0] x_ext, x_inc, x_dec;
  logic [9:0]  nx;
  logic        nf;
  assign x_ext = {1'b0, x_q};
  assign x_inc = x_ext + RUN_V;
  assign x_dec = x_ext - RUN_V;

  // Horizontal step with screen-edge clamping; both-or-neither leaves x and facing alone
  always_comb begin
    nx = x_q;
    nf = fr_q;
    if (btn_r && !btn_l) begin
      nx = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
      nf = 1'b1;
    end else if (btn_l && !btn_r) begin
      nx = (x_ext < RUN_V) ? 10'd0 : x_dec[9:0];
      nf = 1'b0;
    end
  end

  logic signed [11:0] y_s, vy_ext, ny;
  logic signed [8:0]  vy_inc;
  logic signed [7:0]  vy_nxt;
  logic               overlap, plt_cross;
  assign y_s       = signed'({2'b00, y_q});
  assign vy_ext    = {{4{vy_q[7]}}, vy_q};
  assign ny        = y_s + vy_ext;
  assign vy_inc    = {vy_q[7], vy_q} + VY_GRAV;
  assign vy_nxt    = (vy_inc > VY_MAX) ? VY_MAX[7:0] : vy_inc[7:0];
  // Platform overlap uses the post-move x, so a same-tick sidestep can miss or catch the ledge
  assign overlap   = ((x_ext - x_ext + {1'b0, nx} + SPR_W) > PLT_L) && ({1'b0, nx} < PLT_R);
  // Top-edge crossing only, so the platform is never solid from below
  assign plt_cross = (y_s <= PLT_TOP) && (ny >= PLT_TOP) && overlap;

`ifndef PLAYER_PLATFORM_EN
  logic unused_plt;
  assign unused_plt = ^{plt_cross, btn_d, on_plt_q, pm.buttons[6:3]};
`else
  logic unused_btn;
  assign unused_btn = ^pm.buttons[6:3];
`endif

  // Frame-rate motion state machine: all state advances only on frame_tick, rst has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      fr_q     <= FACING_INIT;
      vy_q     <= '0;
      st_q     <= S_FALL;
      f_q      <= '0;
      cnt_q    <= '0;
      a_prev_q <= 1'b0;
      og_q     <= 1'b0;
      on_plt_q <= 1'b0;
    end else if (pm.frame_tick) begin
      x_q      <= nx;
      fr_q     <= nf;
      a_prev_q <= btn_a;
      case (st_q)
        S_IDLE, S_RUN: begin
          if (a_edge) begin
            // Take-off: velocity is set now, first displacement happens next frame
            vy_q     <= VY_JUMP;
            st_q     <= S_JUMP;
            f_q      <= 3'd3;
            og_q     <= 1'b0;
            on_plt_q <= 1'b0;
          end
`ifdef PLAYER_PLATFORM_EN
          else if (on_plt_q && btn_d) begin
            // Drop-through: nudge below the top edge so the crossing test cannot re-catch
            y_q      <= y_q + 10'd1;
            vy_q     <= '0;
            st_q     <= S_FALL;
            f_q      <= 3'd4;
            og_q     <= 1'b0;
            on_plt_q <= 1'b0;
          end else if (on_plt_q && !overlap) begin
            vy_q     <= '0;
            st_q     <= S_FALL;
            f_q      <= 3'd4;
            og_q     <= 1'b0;
            on_plt_q <= 1'b0;
          end
`endif
          else if (one_dir) begin
            st_q <= S_RUN;
            og_q <= 1'b1;
            if (st_q == S_RUN) begin
              if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                f_q   <= (f_q == 3'd5) ? 3'd0 : f_q + 3'd1;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end else begin
              f_q   <= '0;
              cnt_q <= '0;
            end
          end else begin
            st_q  <= S_IDLE;
            og_q  <= 1'b1;
            f_q   <= '0;
            cnt_q <= '0;
          end
        end
        default: begin
          if (ny < 12'sd0) begin
            y_q  <= '0;
            vy_q <= '0;
            st_q <= S_FALL;
            f_q  <= 3'd4;
          end
`ifdef PLAYER_PLATFORM_EN
          else if (st_q == S_FALL && plt_cross) begin
            y_q      <= PLT_TOP[9:0];
            vy_q     <= '0;
            st_q     <= one_dir ? S_RUN : S_IDLE;
            og_q     <= 1'b1;
            f_q      <= '0;
            cnt_q    <= '0;
            on_plt_q <= 1'b1;
          end
`endif
          else if (ny >= GND_Y) begin
            y_q      <= GND_Y[9:0];
            vy_q     <= '0;
            st_q     <= one_dir ? S_RUN : S_IDLE;
            og_q     <= 1'b1;
            f_q      <= '0;
            cnt_q    <= '0;
            on_plt_q <= 1'b0;
          end else begin
            y_q  <= ny[9:0];
            vy_q <= vy_nxt;
            if (!vy_nxt[7]) begin
              st_q <= S_FALL;
              f_q  <= 3'd4;
            end else begin
              st_q <= S_JUMP;
              f_q  <= 3'd3;
            end
          end
        end
      endcase
    end
  end

  logic [9:0] row_d, col_d;
  // Sprite-sheet offsets: two rows of three frames
  always_comb begin
    row_d = (f_q >= 3'd3) ? 10'd30 : 10'd0;
    case (f_q)
      3'd1, 3'd4: col_d = 10'd23;
      3'd2, 3'd5: col_d = 10'd46;
      default:    col_d = 10'd0;
    endcase
  end

  assign pm.pos_x        = x_q;
  assign pm.pos_y        = y_q;
  assign pm.facing_right = fr_q;
  assign pm.anim_row     = row_d;
  assign pm.anim_col     = col_d;
  assign pm.on_ground    = og_q;
  assign pm.mstate       = st_q;

endmodule
